// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port word memory between the CPU (port 0)
// and a boot/debug loader (port 1), with loader lock, starvation guard and registered memory bus.
module mem_arbiter #(
  parameter int unsigned AW       = 7,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_LOCK = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_lock,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned    CW      = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_LOCK);

  logic          last_p1;
  logic          lock_owner;
  logic [CW-1:0] lock_cnt;
  logic          gnt0;
  logic          gnt1;
  logic          xfer0;
  logic          xfer1;
  logic          rd_pend;
  logic          rd_port;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (p0_req && p1_req) begin
      if (lock_owner) begin
        // a saturated lock counter yields exactly one grant to the CPU
        if (lock_cnt == CNT_MAX) gnt0 = 1'b1;
        else                     gnt1 = 1'b1;
      end else if (last_p1) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = p0_req;
      gnt1 = p1_req;
    end
  end

  assign p0_gnt = gnt0 & rst_n;
  assign p1_gnt = gnt1 & rst_n;
  assign xfer0  = p0_req & p0_gnt;
  assign xfer1  = p1_req & p1_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_p1    <= 1'b1;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
    end else if (xfer0) begin
      last_p1  <= 1'b0;
      lock_cnt <= '0;
    end else if (xfer1) begin
      last_p1 <= 1'b1;
      if (p1_lock) begin
        lock_owner <= 1'b1;
        if (p0_req && lock_cnt != CNT_MAX) lock_cnt <= lock_cnt + CW'(1);
      end else begin
        lock_owner <= 1'b0;
        lock_cnt   <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_pend   <= 1'b0;
      rd_port   <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      mem_we <= (xfer0 & p0_we) | (xfer1 & p1_we);
      if (xfer0) begin
        mem_addr  <= p0_addr;
        mem_wdata <= p0_wdata;
      end else if (xfer1) begin
        mem_addr  <= p1_addr;
        mem_wdata <= p1_wdata;
      end
      // the issuing port travels alongside the read so only it sees rvalid
      rd_pend   <= (xfer0 & ~p0_we) | (xfer1 & ~p1_we);
      rd_port   <= xfer1;
      p0_rvalid <= rd_pend & ~rd_port;
      p1_rvalid <= rd_pend & rd_port;
    end
  end

  assign p0_rdata = mem_rdata;
  assign p1_rdata = mem_rdata;

endmodule
